// File: rtl/du_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among word-producing requesters.
// Each granted word is latched and sent LSB-first, one byte per tx_start/tx_done handshake.

module du_tx_arbiter #(
  parameter int N_REQ     = 5,
  parameter int NB_DATA   = 32,
  parameter int N_BITS    = 8,
  parameter int N_BYTES   = 4,
  parameter int NB_CNT    = 3,
  parameter int N_TIMEOUT = 0
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB_DATA-1:0] i_data,
  input  logic [N_REQ*NB_CNT-1:0]  i_nbytes,
  input  logic                     i_tx_done_tick,
  output logic [N_BITS-1:0]        o_tx_data,
  output logic                     o_tx_start,
  output logic [N_REQ-1:0]         o_ack,
  output logic [2:0]               o_owner,
  output logic                     o_busy,
  output logic                     o_timeout
);

  // state     | meaning
  // IDLE      | no transfer; round-robin grant on any request
  // START     | o_tx_start pulse for the current byte
  // WAIT_DONE | waiting for the UART done tick, watchdog counting down
  // ACK       | one-cycle o_ack to the owner; round-robin pointer advances
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, ACK} state_t;

  localparam int OW = 3;
  localparam int WD_W = $clog2(N_TIMEOUT + 2);
  localparam logic [WD_W-1:0] WD_INIT = (N_TIMEOUT > 0) ? WD_W'(N_TIMEOUT - 1) : '0;

  state_t              state_q, state_d;
  logic [NB_DATA-1:0]  word_q, word_d;
  logic [NB_CNT-1:0]   nbytes_q, nbytes_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       last_q, last_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [N_BITS-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;

  logic                gnt_vld;
  logic [OW-1:0]       gnt_idx;
  logic [OW-1:0]       scan_idx;
  logic [NB_CNT-1:0]   req_nb;
  logic [NB_CNT-1:0]   eff_nb;
  logic                wd_expired;

  // First requester after the last owner, wrapping modulo N_REQ.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      scan_idx = OW'((int'(last_q) + i) % N_REQ);
      if (!gnt_vld && i_req[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  always_comb begin
    req_nb = i_nbytes[gnt_idx*NB_CNT +: NB_CNT];
    eff_nb = ((req_nb == '0) || (req_nb > NB_CNT'(N_BYTES))) ? NB_CNT'(N_BYTES) : req_nb;
  end

  assign wd_expired = (N_TIMEOUT > 0) && (wd_q == '0);

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    nbytes_d   = nbytes_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    last_d     = last_q;
    wd_d       = wd_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    ack_d      = '0;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d    = START;
          word_d     = i_data[gnt_idx*NB_DATA +: NB_DATA];
          nbytes_d   = eff_nb;
          cnt_d      = '0;
          owner_d    = gnt_idx;
          busy_d     = 1'b1;
          tx_start_d = 1'b1;
          tx_data_d  = i_data[gnt_idx*NB_DATA +: N_BITS];
        end
      end
      START: begin
        state_d   = WAIT_DONE;
        wd_d      = WD_INIT;
        timeout_d = (N_TIMEOUT == 1);
      end
      WAIT_DONE: begin
        // The watchdog abort still acknowledges so the requester cannot deadlock.
        if (wd_expired) begin
          state_d        = ACK;
          ack_d[owner_q] = 1'b1;
        end else if (i_tx_done_tick) begin
          if (cnt_q == nbytes_q - 1'b1) begin
            state_d        = ACK;
            ack_d[owner_q] = 1'b1;
          end else begin
            cnt_d      = cnt_q + 1'b1;
            state_d    = START;
            tx_start_d = 1'b1;
            tx_data_d  = word_q[cnt_d*N_BITS +: N_BITS];
          end
        end else if (N_TIMEOUT > 0) begin
          wd_d      = wd_q - 1'b1;
          timeout_d = (wd_q == WD_W'(1));
        end
      end
      ACK: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      word_q     <= '0;
      nbytes_q   <= '0;
      cnt_q      <= '0;
      owner_q    <= '0;
      last_q     <= OW'(N_REQ - 1);
      wd_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      nbytes_q   <= nbytes_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      wd_q       <= wd_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_ack      = ack_q;
  assign o_owner    = owner_q;
  assign o_busy     = busy_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_du_tx_arbiter.sv
// Self-checking bench for du_tx_arbiter: a transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed byte, ack and timing expectations.

module tb_du_tx_arbiter;
  localparam int N = 5;
  localparam int T = 16;

  logic         clk;
  logic         i_reset;
  logic [4:0]   i_req;
  logic [159:0] i_data;
  logic [14:0]  i_nbytes;
  logic         tb_tick;
  logic [7:0]   o_tx_data;
  logic         o_tx_start;
  logic [4:0]   o_ack;
  logic [2:0]   o_owner;
  logic         o_busy;
  logic         o_timeout;

  du_tx_arbiter #(
    .N_REQ(5), .NB_DATA(32), .N_BITS(8), .N_BYTES(4), .NB_CNT(3), .N_TIMEOUT(T)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_req(i_req), .i_data(i_data),
    .i_nbytes(i_nbytes), .i_tx_done_tick(tb_tick), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .o_ack(o_ack), .o_owner(o_owner), .o_busy(o_busy),
    .o_timeout(o_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- UART responder: one tick tick_delay cycles after each start
  int tick_delay = 10;
  bit spur_start = 1'b0;
  int force_req = 0;
  int force_done = 0;
  int cd = 0;

  initial begin
    tb_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tb_tick = 1'b0;
      if (!i_reset) cd = 0;
      else if (o_tx_start) begin
        cd = tick_delay;
        if (spur_start) tb_tick = 1'b1;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) tb_tick = 1'b1;
      end
      if (force_req != force_done) begin
        tb_tick = 1'b1;
        force_done++;
      end
    end
  end

  // ---------------- reference model: one word at a time, timed from the rules
  logic       e_start, e_timeout, e_busy;
  logic [7:0] e_data;
  logic [4:0] e_ack;
  int         e_owner;
  int         m_last;

  task automatic m_reset();
    e_start = 0; e_timeout = 0; e_busy = 0; e_data = '0; e_ack = '0;
    e_owner = 0; m_last = N - 1;
  endtask

  task automatic m_word();
    int own, nb, n;
    logic [31:0] w;
    bit done, abort;
    own = -1;
    for (int i = 1; i <= N; i++)
      if (own < 0 && i_req[(m_last + i) % N]) own = (m_last + i) % N;
    w  = i_data[own*32 +: 32];
    nb = int'(i_nbytes[own*3 +: 3]);
    n  = (nb == 0 || nb > 4) ? 4 : nb;
    e_owner = own;
    e_busy  = 1;
    abort   = 0;
    for (int b = 0; b < n && !abort; b++) begin
      e_start = 1;
      e_data  = w[b*8 +: 8];
      done    = 0;
      // k counts edges since the start cycle; a tick in the start cycle itself is ignored
      for (int k = 0; !done; k++) begin
        @(posedge clk);
        if (!i_reset) begin m_reset(); return; end
        e_start = 0;
        if (k == T) begin abort = 1; done = 1; e_timeout = 0; end
        else if (k > 0 && tb_tick) done = 1;
        else if (k == T - 1) e_timeout = 1;
      end
    end
    e_ack = 5'b00001 << own;
    @(posedge clk);
    if (!i_reset) begin m_reset(); return; end
    e_ack  = '0;
    e_busy = 0;
    m_last = own;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (!i_reset) m_reset();
      else begin
        e_ack = '0; e_timeout = 0; e_start = 0;
        if (i_req != 0) m_word();
      end
    end
  end

  // ---------------- compare process and event logs
  int         start_cyc[$];
  logic [7:0] start_byte[$];
  logic [4:0] ack_val[$];
  int         ack_cyc[$];
  int         to_cyc[$];
  int         tick_cyc[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (o_tx_start === 1'b1) begin start_cyc.push_back(cyc); start_byte.push_back(o_tx_data); end
      if (o_ack !== 5'b0 && !$isunknown(o_ack)) begin ack_val.push_back(o_ack); ack_cyc.push_back(cyc); end
      if (o_timeout === 1'b1) to_cyc.push_back(cyc);
      if (tb_tick) tick_cyc.push_back(cyc);
      if (cmp_en) begin
        chk("cyc_tx_start", o_tx_start, e_start);
        chk("cyc_tx_data", o_tx_data, e_data);
        chk("cyc_ack", o_ack, e_ack);
        chk("cyc_busy", o_busy, e_busy);
        chk("cyc_timeout", o_timeout, e_timeout);
        if (e_busy) chk("cyc_owner", o_owner, e_owner);
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int k, input logic [31:0] d, input logic [2:0] nb);
    i_data[k*32 +: 32] = d;
    i_nbytes[k*3 +: 3] = nb;
  endtask

  task automatic serve(input logic [4:0] mask, input int budget);
    logic [4:0] pend;
    int n;
    pend = mask;
    n = 0;
    i_req = i_req | mask;
    while (pend != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if ((o_ack & pend) != 0) begin
        i_req = i_req & ~o_ack;
        pend  = pend & ~o_ack;
      end
    end
    chk("serve_all_acked", pend, 5'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b0;
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
  endtask

  logic [7:0] exp1 [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [4:0] exp3 [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

  initial begin
    int b0, a0, t0, o0, n;
    i_reset = 1'b0; i_req = '0; i_data = '0; i_nbytes = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_outputs", {o_tx_data, o_tx_start, o_ack, o_owner, o_busy, o_timeout}, 0);
    i_reset = 1'b1;
    settle(2);

    // 4-byte word, tick 10 cycles after each start
    tick_delay = 10;
    set_word(0, 32'hDEADBEEF, 3'd4);
    b0 = start_byte.size(); a0 = ack_val.size();
    serve(5'b00001, 200);
    settle(3);
    chk("t1_nstart", start_byte.size() - b0, 4);
    for (int i = 0; i < 4; i++) chk("t1_byte", start_byte[b0+i], exp1[i]);
    chk("t1_ack", ack_val[a0], 5'b00001);
    chk("t1_ack_after_tick", ack_cyc[a0] - tick_cyc[tick_cyc.size()-1], 1);
    chk("t1_span", ack_cyc[a0] - start_cyc[b0], 44);
    chk("t1_busy_after", o_busy, 1'b0);

    // single byte, then count 0 meaning full width
    tick_delay = 4;
    set_word(2, 32'h00000037, 3'd1);
    b0 = start_byte.size(); a0 = ack_val.size();
    serve(5'b00100, 100);
    settle(3);
    chk("t2a_nstart", start_byte.size() - b0, 1);
    chk("t2a_byte", start_byte[b0], 8'h37);
    chk("t2a_ack", ack_val[a0], 5'b00100);
    set_word(2, 32'h00000037, 3'd0);
    b0 = start_byte.size(); a0 = ack_val.size();
    serve(5'b00100, 100);
    settle(3);
    chk("t2b_nstart", start_byte.size() - b0, 4);
    chk("t2b_byte0", start_byte[b0], 8'h37);
    chk("t2b_byte3", start_byte[b0+3], 8'h00);
    chk("t2b_ack", ack_val[a0], 5'b00100);

    // spurious ticks in IDLE and in the START cycle
    force_req++;
    settle(4);
    chk("t4_idle_busy", o_busy, 1'b0);
    spur_start = 1'b1;
    tick_delay = 5;
    set_word(1, 32'h00001234, 3'd2);
    b0 = start_byte.size(); a0 = ack_val.size();
    serve(5'b00010, 100);
    settle(3);
    spur_start = 1'b0;
    chk("t4_nstart", start_byte.size() - b0, 2);
    chk("t4_byte0", start_byte[b0], 8'h34);
    chk("t4_byte1", start_byte[b0+1], 8'h12);
    chk("t4_ack", ack_val[a0], 5'b00010);
    chk("t4_span", ack_cyc[a0] - start_cyc[b0], 12);

    // all requesters held: round-robin order
    do_reset();
    settle(2);
    tick_delay = 3;
    for (int k = 0; k < 5; k++) set_word(k, 32'h10 + k, 3'd1);
    b0 = start_byte.size(); a0 = ack_val.size();
    i_req = 5'b11111;
    n = 0;
    while (ack_val.size() - a0 < 6 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    i_req = '0;
    settle(3);
    chk("t3_nack", ack_val.size() - a0, 6);
    for (int i = 0; i < 6; i++) begin
      chk("t3_ack_order", ack_val[a0+i], exp3[i]);
      chk("t3_byte", start_byte[b0+i], 8'h10 + 8'(i % 5));
    end

    // reset after the 2nd byte of a 4-byte word
    tick_delay = 10;
    set_word(3, 32'h11223344, 3'd4);
    t0 = tick_cyc.size(); a0 = ack_val.size();
    i_req = 5'b01000;
    n = 0;
    while (tick_cyc.size() - t0 < 2 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t5_two_ticks", tick_cyc.size() - t0, 2);
    @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_reset_outputs", {o_tx_data, o_tx_start, o_ack, o_owner, o_busy, o_timeout}, 0);
    i_reset = 1'b1;
    i_req = '0;
    settle(30);
    chk("t5_no_ack", ack_val.size() - a0, 0);
    set_word(0, 32'h000000A5, 3'd1);
    set_word(3, 32'h0000005A, 3'd1);
    b0 = start_byte.size();
    serve(5'b01001, 200);
    settle(3);
    chk("t5_first_ack", ack_val[a0], 5'b00001);
    chk("t5_second_ack", ack_val[a0+1], 5'b01000);
    chk("t5_first_byte", start_byte[b0], 8'hA5);
    chk("t5_second_byte", start_byte[b0+1], 8'h5A);

    // watchdog: never tick
    tick_delay = 0;
    set_word(4, 32'hCAFEF00D, 3'd2);
    b0 = start_byte.size(); a0 = ack_val.size(); o0 = to_cyc.size();
    serve(5'b10000, 100);
    settle(3);
    chk("t6_ntimeout", to_cyc.size() - o0, 1);
    chk("t6_timeout_lat", to_cyc[o0] - start_cyc[b0], 16);
    chk("t6_ack_after_to", ack_cyc[a0] - to_cyc[o0], 1);
    chk("t6_ack", ack_val[a0], 5'b10000);
    chk("t6_nstart", start_byte.size() - b0, 1);
    chk("t6_byte", start_byte[b0], 8'h0D);
    chk("t6_busy_after", o_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
